// File: rtl/jtag_pkg.sv
// rtl/jtag_pkg.sv - shared widths and FSM state type for the JTAG user-DR sequencer
// Purpose : default widths and the scan FSM state encoding shared by the
//           sequencer, its interface and the testbench.
// Ports   : none (package).
package jtag_pkg;

    localparam int DEF_DATA_WIDTH   = 8;
    localparam int DEF_RESULT_WIDTH = 32;
    localparam int DEF_FIFO_DEPTH   = 4;

    // Scan-length counter width; saturates at 2**CNT_WIDTH-1.
    localparam int CNT_WIDTH = 6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } scan_state_t;

endpackage

// File: rtl/scan_dr_sequencer_if.sv
// rtl/scan_dr_sequencer_if.sv - character stream and readback result bundle
// Purpose : groups the byte stream to user logic and the result returned by it.
// Ports   : byte_valid/byte_data (sequencer -> user), byte_ready (user -> sequencer),
//           result_valid/result (user -> sequencer).
//           master = sequencer side, slave = user-logic side.
interface scan_dr_sequencer_if
    import jtag_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int RESULT_WIDTH = DEF_RESULT_WIDTH
);

    logic                    byte_valid;
    logic [DATA_WIDTH-1:0]   byte_data;
    logic                    byte_ready;
    logic                    result_valid;
    logic [RESULT_WIDTH-1:0] result;

    modport master (
        output byte_valid,
        output byte_data,
        input  byte_ready,
        input  result_valid,
        input  result
    );

    modport slave (
        input  byte_valid,
        input  byte_data,
        output byte_ready,
        output result_valid,
        output result
    );

endinterface

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - small first-word fall-through byte FIFO
// Purpose : buffers committed characters until the user logic accepts them.
// Ports   : clk, rst (async, active-high), push/push_data (write), pop (read),
//           full, empty, head (current front entry, valid when !empty).
module byte_fifo
    import jtag_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic                  full,
    output logic                  empty,
    output logic [DATA_WIDTH-1:0] head
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           count;
    logic                  do_push;
    logic                  do_pop;

    assign full  = (count == (AW+1)'(FIFO_DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // A push into a full FIFO still lands when a pop frees the slot in the same cycle.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/scan_dr_sequencer.sv
// rtl/scan_dr_sequencer.sv - JTAG user DR scan sequencer with byte queue and readback
// Purpose : turns DATA_WIDTH-bit user DR scans into queued characters and
//           RESULT_WIDTH-bit scans into readback of the user result word.
// Ports   : tck, test_logic_reset (async, active-high); tdi/tdo serial data;
//           ir_is_user, capture_dr, shift_dr, update_dr TAP qualifiers;
//           bus (master): byte stream out, result in; overflow, bad_scan sticky flags.
module scan_dr_sequencer
    import jtag_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int RESULT_WIDTH = DEF_RESULT_WIDTH,
    parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
    input  logic                 tck,
    input  logic                 test_logic_reset,
    input  logic                 tdi,
    output logic                 tdo,
    input  logic                 ir_is_user,
    input  logic                 capture_dr,
    input  logic                 shift_dr,
    input  logic                 update_dr,
    output logic                 overflow,
    output logic                 bad_scan,
    scan_dr_sequencer_if.master  bus
);

    localparam logic [CNT_WIDTH-1:0] CNT_DATA   = CNT_WIDTH'(DATA_WIDTH);
    localparam logic [CNT_WIDTH-1:0] CNT_RESULT = CNT_WIDTH'(RESULT_WIDTH);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;

    scan_state_t             state;
    logic [RESULT_WIDTH-1:0] sr;
    logic [CNT_WIDTH-1:0]    cnt;

    logic                    capture_user;
    logic                    shift_user;
    logic                    update_user;
    logic [RESULT_WIDTH-1:0] capture_value;
    logic                    push;
    logic                    pop;
    logic                    scan_bad;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [DATA_WIDTH-1:0]   fifo_head;

    // Qualifiers only count while the user instruction is selected.
    assign capture_user  = ir_is_user & capture_dr;
    assign shift_user    = ir_is_user & shift_dr;
    assign update_user   = ir_is_user & update_dr;
    assign capture_value = bus.result_valid ? bus.result : '0;

    // First result bit is on tdo straight after capture, before any shift edge.
    assign tdo = sr[0];

    // Bits enter at the MSB, so an LSB-first character ends up in the top DATA_WIDTH bits.
    assign push     = (state == COMMIT) && (cnt == CNT_DATA);
    assign scan_bad = (state == COMMIT) && (cnt != CNT_DATA) && (cnt != CNT_RESULT);
    assign pop      = bus.byte_valid & bus.byte_ready;

    assign bus.byte_valid = ~fifo_empty;
    assign bus.byte_data  = fifo_empty ? '0 : fifo_head;

    always_ff @(posedge tck or posedge test_logic_reset) begin
        if (test_logic_reset) begin
            state    <= IDLE;
            sr       <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
            bad_scan <= 1'b0;
        end else begin
            if (push && fifo_full && !pop) begin
                overflow <= 1'b1;
            end
            if (scan_bad) begin
                bad_scan <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (capture_user) begin
                        sr    <= capture_value;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    // A fresh capture abandons the scan in progress without committing.
                    if (capture_user) begin
                        sr  <= capture_value;
                        cnt <= '0;
                    end else if (update_user) begin
                        state <= COMMIT;
                    end else if (shift_user) begin
                        sr <= {tdi, sr[RESULT_WIDTH-1:1]};
                        if (cnt != CNT_MAX) begin
                            cnt <= cnt + CNT_WIDTH'(1);
                        end
                    end
                end
                COMMIT: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    byte_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_byte_fifo (
        .clk       (tck),
        .rst       (test_logic_reset),
        .push      (push),
        .push_data (sr[RESULT_WIDTH-1 -: DATA_WIDTH]),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

endmodule

// File: tb/tb_scan_dr_sequencer.sv
// tb/tb_scan_dr_sequencer.sv - directed self-checking bench for scan_dr_sequencer
module tb_scan_dr_sequencer;

    logic tck;
    logic test_logic_reset;
    logic tdi;
    logic tdo;
    logic ir_is_user;
    logic capture_dr;
    logic shift_dr;
    logic update_dr;
    logic overflow;
    logic bad_scan;

    int n_checks;
    int n_pass;

    logic [31:0] rd;

    scan_dr_sequencer_if #(.DATA_WIDTH(8), .RESULT_WIDTH(32)) bus ();

    scan_dr_sequencer #(
        .DATA_WIDTH   (8),
        .RESULT_WIDTH (32),
        .FIFO_DEPTH   (4)
    ) dut (
        .tck              (tck),
        .test_logic_reset (test_logic_reset),
        .tdi              (tdi),
        .tdo              (tdo),
        .ir_is_user       (ir_is_user),
        .capture_dr       (capture_dr),
        .shift_dr         (shift_dr),
        .update_dr        (update_dr),
        .overflow         (overflow),
        .bad_scan         (bad_scan),
        .bus              (bus)
    );

    initial begin
        tck = 1'b0;
        forever #5 tck = ~tck;
    end

    task automatic tick();
        @(posedge tck);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", name, got, exp);
    endtask

    // Full user scan: capture, nbits shifts, update, COMMIT cycle; returns tdo bits.
    task automatic scan(input int nbits, input logic [31:0] data, input bit pop_at_commit,
                        output logic [31:0] bits);
        bits = '0;
        ir_is_user = 1'b1;
        capture_dr = 1'b1;
        tick();
        capture_dr = 1'b0;
        shift_dr   = 1'b1;
        for (int i = 0; i < nbits; i++) begin
            tdi     = data[i];
            bits[i] = tdo;
            tick();
        end
        shift_dr  = 1'b0;
        tdi       = 1'b0;
        update_dr = 1'b1;
        tick();
        update_dr = 1'b0;
        if (pop_at_commit) bus.byte_ready = 1'b1;
        tick();
        if (pop_at_commit) bus.byte_ready = 1'b0;
    endtask

    task automatic do_reset();
        test_logic_reset = 1'b1;
        tick();
        tick();
        test_logic_reset = 1'b0;
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_logic_reset = 1'b1;
        tdi = 1'b0; ir_is_user = 1'b0; capture_dr = 1'b0; shift_dr = 1'b0; update_dr = 1'b0;
        bus.byte_ready = 1'b0; bus.result_valid = 1'b0; bus.result = '0;

        // Reset state
        tick();
        tick();
        check("rst_byte_valid", 32'(bus.byte_valid), 32'd0);
        check("rst_byte_data",  32'(bus.byte_data),  32'd0);
        check("rst_tdo",        32'(tdo),            32'd0);
        check("rst_overflow",   32'(overflow),       32'd0);
        check("rst_bad_scan",   32'(bad_scan),       32'd0);
        test_logic_reset = 1'b0;
        tick();

        // Two characters with byte_ready high: one-cycle valid pulses
        bus.byte_ready = 1'b1;
        scan(8, 32'h31, 1'b0, rd);
        check("s1_valid_a", 32'(bus.byte_valid), 32'd1);
        check("s1_data_a",  32'(bus.byte_data),  32'h31);
        tick();
        check("s1_pulse_a", 32'(bus.byte_valid), 32'd0);
        scan(8, 32'h0A, 1'b0, rd);
        check("s1_valid_b", 32'(bus.byte_valid), 32'd1);
        check("s1_data_b",  32'(bus.byte_data),  32'h0A);
        tick();
        check("s1_pulse_b", 32'(bus.byte_valid), 32'd0);
        check("s1_overflow", 32'(overflow), 32'd0);

        // Five characters with byte_ready low: fifth dropped, overflow set
        bus.byte_ready = 1'b0;
        for (int i = 0; i < 5; i++) scan(8, 32'h41 + 32'(i), 1'b0, rd);
        check("s2_overflow", 32'(overflow), 32'd1);
        check("s2_hold",     32'(bus.byte_data), 32'h41);
        tick();
        check("s2_hold2",    32'(bus.byte_data), 32'h41);
        bus.byte_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("s2_pop_valid", 32'(bus.byte_valid), 32'd1);
            check("s2_pop_data",  32'(bus.byte_data),  32'h41 + 32'(i));
            tick();
        end
        check("s2_drained", 32'(bus.byte_valid), 32'd0);
        bus.byte_ready = 1'b0;

        // Push coinciding with a pop on a full FIFO is accepted without overflow
        do_reset();
        for (int i = 0; i < 4; i++) scan(8, 32'h41 + 32'(i), 1'b0, rd);
        scan(8, 32'h46, 1'b1, rd);
        check("cc_overflow", 32'(overflow), 32'd0);
        bus.byte_ready = 1'b1;
        check("cc_data0", 32'(bus.byte_data), 32'h42);
        tick();
        check("cc_data1", 32'(bus.byte_data), 32'h43);
        tick();
        check("cc_data2", 32'(bus.byte_data), 32'h44);
        tick();
        check("cc_data3", 32'(bus.byte_data), 32'h46);
        tick();
        check("cc_empty", 32'(bus.byte_valid), 32'd0);
        bus.byte_ready = 1'b0;

        // Qualifiers ignored while ir_is_user is low
        do_reset();
        ir_is_user = 1'b0;
        capture_dr = 1'b1;
        tick();
        capture_dr = 1'b0;
        update_dr  = 1'b1;
        tick();
        update_dr  = 1'b0;
        tick();
        tick();
        check("noir_bad_scan", 32'(bad_scan), 32'd0);

        // Readback of a valid result, LSB first, nothing queued
        bus.result_valid = 1'b1;
        bus.result = 32'h0000_0E5A;
        scan(32, 32'h0, 1'b0, rd);
        check("rb_value",    rd, 32'h0000_0E5A);
        check("rb_no_byte",  32'(bus.byte_valid), 32'd0);
        check("rb_bad_scan", 32'(bad_scan), 32'd0);

        // Readback with no valid result returns zero
        bus.result_valid = 1'b0;
        scan(32, 32'h0, 1'b0, rd);
        check("rb0_value", rd, 32'h0);

        // Bad length then a good character
        scan(5, 32'h1F, 1'b0, rd);
        check("bad_flag",    32'(bad_scan), 32'd1);
        check("bad_no_byte", 32'(bus.byte_valid), 32'd0);
        bus.byte_ready = 1'b1;
        scan(8, 32'h28, 1'b0, rd);
        check("bad_next_data",  32'(bus.byte_data), 32'h28);
        check("bad_next_valid", 32'(bus.byte_valid), 32'd1);
        check("bad_sticky",     32'(bad_scan), 32'd1);
        tick();

        // Reset mid-scan after 4 shift bits
        bus.result_valid = 1'b1;
        bus.result = 32'hFFFF_FFFF;
        ir_is_user = 1'b1;
        capture_dr = 1'b1;
        tick();
        capture_dr = 1'b0;
        shift_dr   = 1'b1;
        tdi        = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("mid_tdo_before", 32'(tdo), 32'd1);
        test_logic_reset = 1'b1;
        #1;
        check("mid_tdo_async",  32'(tdo), 32'd0);
        check("mid_bad_async",  32'(bad_scan), 32'd0);
        tick();
        tick();
        check("mid_tdo_hold",   32'(tdo), 32'd0);
        check("mid_valid_hold", 32'(bus.byte_valid), 32'd0);
        shift_dr = 1'b0;
        tdi = 1'b0;
        bus.result_valid = 1'b0;
        test_logic_reset = 1'b0;
        tick();
        scan(8, 32'h29, 1'b0, rd);
        check("mid_data",  32'(bus.byte_data), 32'h29);
        check("mid_valid", 32'(bus.byte_valid), 32'd1);
        tick();
        check("mid_single",   32'(bus.byte_valid), 32'd0);
        check("mid_overflow", 32'(overflow), 32'd0);
        check("mid_bad_scan", 32'(bad_scan), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/scan_dr_sequencer.md
SCAN_DR_SEQUENCER -- requirements
Module: scan_dr_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, the width of one input-character DR scan.
REQ-002 SHALL have parameter RESULT_WIDTH, default 32, the width of one readback DR scan.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, the byte buffer depth; it is a power of two and at least 2.
REQ-004 SHALL have port tck, input, 1 bit: the single clock (JTAG TCK); all state updates on its rising edge.
REQ-005 SHALL have port test_logic_reset, input, 1 bit: the reset, asynchronous and active-high.
REQ-006 SHALL have ports tdi (input, 1 bit, serial in) and tdo (output, 1 bit, serial out).
REQ-007 SHALL have ports ir_is_user, capture_dr, shift_dr and update_dr, each an input of 1 bit: the TAP state qualifiers.
REQ-008 SHALL have ports byte_valid (output, 1 bit), byte_data (output, DATA_WIDTH bits) and byte_ready (input, 1 bit): the character stream to the user logic.
REQ-009 SHALL have ports result_valid (input, 1 bit) and result (input, RESULT_WIDTH bits): the answer from the user logic.
REQ-010 SHALL have ports overflow (output, 1 bit, sticky dropped-byte flag) and bad_scan (output, 1 bit, sticky bad-scan-length flag).

Function
REQ-011 SHALL implement FSM states IDLE, SHIFT and COMMIT.
REQ-012 SHALL leave IDLE for SHIFT only on capture_dr=1 with ir_is_user=1, and SHALL ignore every qualifier while ir_is_user=0.
REQ-013 SHALL, on capture, load shift register sr (RESULT_WIDTH bits) with result if result_valid=1, otherwise with 0, and SHALL clear bit counter cnt.
REQ-014 SHALL make tdo equal sr[0] combinationally, so the first result bit is visible before the first shift_dr edge.
REQ-015 SHALL, in SHIFT on each edge with shift_dr=1, set sr to {tdi, sr[RESULT_WIDTH-1:1]} (LSB first) and increment cnt, saturating at 63 (6 bits).
REQ-016 SHALL move from SHIFT to COMMIT on update_dr=1, and SHALL spend exactly one cycle in COMMIT before returning to IDLE.
REQ-017 SHALL, in COMMIT with cnt==DATA_WIDTH, push sr[RESULT_WIDTH-1 -: DATA_WIDTH] into the FIFO.
REQ-018 SHALL, in COMMIT with cnt==RESULT_WIDTH, treat the scan as a readback and push nothing.
REQ-019 SHALL, in COMMIT with any other cnt (including 0), set bad_scan and push nothing.
REQ-020 SHALL, when the FIFO is full at a push, drop the byte and set overflow, leaving FIFO contents unchanged.
REQ-021 SHALL, when a push and a pop (byte_valid and byte_ready) coincide on a full FIFO, accept the push without setting overflow.
REQ-022 SHALL assert byte_valid whenever the FIFO is non-empty, with byte_data at the FIFO head (first-word fall-through).
REQ-023 SHALL deliver a byte on byte_valid no later than one cycle after COMMIT.
REQ-024 SHALL pop the FIFO only on byte_valid and byte_ready together, and SHALL hold byte_data stable while byte_valid=1 and byte_ready=0.
REQ-025 SHALL, on capture_dr=1 while in SHIFT (a rescan with no update), restart the scan without committing anything.

Reset
REQ-026 SHALL, on test_logic_reset=1 at any time including mid-scan, immediately force state IDLE, sr=0, cnt=0, FIFO empty, byte_valid=0, byte_data=0, overflow=0, bad_scan=0 and tdo=0.
REQ-027 SHALL hold that reset state for as long as test_logic_reset=1.
REQ-028 SHALL keep overflow and bad_scan sticky until the next reset.

Structure
REQ-029 SHALL take the FSM state enum and the default widths (8, 32, 4) from the shared package jtag_pkg.
REQ-030 SHALL implement the FIFO as sub-module byte_fifo (parameters DATA_WIDTH and FIFO_DEPTH; ports push, pop, full, empty and head), using the same clock and reset.

Verification
REQ-031 SHALL pass this scenario: 8-bit scans of 0x31, 0x0A with byte_ready=1 produce byte_data 0x31 then 0x0A, each byte_valid pulse one cycle long, and overflow=0.
REQ-032 SHALL pass this scenario: with byte_ready=0, five 8-bit scans (0x41..0x45) leave bytes 0x41..0x44 queued, overflow=1, and later pops return 0x41..0x44 in order.
REQ-033 SHALL pass this scenario: with result_valid=1 and result=0x0000_0E5A, a 32-bit scan with tdi=0 reads 0x0000_0E5A LSB first on tdo, and the FIFO stays empty.
REQ-034 SHALL pass this scenario: a 32-bit readback with result_valid=0 returns 0x0000_0000.
REQ-035 SHALL pass this scenario: a 5-bit scan sets bad_scan=1, pushes no byte, and a following 8-bit scan of 0x28 still delivers 0x28.
REQ-036 SHALL pass this scenario: asserting test_logic_reset after 4 shift bits, then a full 8-bit scan of 0x29, yields exactly one byte 0x29 with overflow=0 and bad_scan=0.
